// File: rtl/mlp_pkg.sv
// mlp_pkg: shared sizes, matrix types and transmitter state encoding for the MLP result path.
package mlp_pkg;
    localparam int DEF_ROWS = 16;
    localparam int DEF_COLS = 16;
    localparam int DEF_DW = 16;
    localparam int DEF_OUT_W = 2 * DEF_DW;
    localparam int WORDS_PER_MAT = DEF_ROWS * DEF_COLS / 2;
    typedef logic [DEF_DW-1:0] elem_t;
    typedef elem_t [DEF_COLS-1:0] row_t;
    typedef row_t [DEF_ROWS-1:0] mat_t;
    typedef enum logic {COLLECT, SEND} tx_state_e;
endpackage

// File: rtl/mlp_tx_buffer.sv
// mlp_tx_buffer: row-pair write port into a row-major element store, with a word-index read mux.
module mlp_tx_buffer import mlp_pkg::*; #(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW = DEF_DW,
    parameter int OUT_W = DEF_OUT_W,
    parameter int PW = 3,
    parameter int CW = 7
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [PW-1:0]          wr_pair,
    input  logic [2*COLS*DW-1:0]   wr_data,
    input  logic [CW-1:0]          rd_idx,
    output logic [OUT_W-1:0]       rd_word
);
    localparam int EW = $clog2(ROWS * COLS);
    logic [DW-1:0] mem [ROWS*COLS];
    logic [EW-1:0] base;
    assign base = EW'(wr_pair) * EW'(2 * COLS);
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < COLS; c++) begin
                mem[base + EW'(c)] <= wr_data[c*DW +: DW];
                mem[base + EW'(COLS + c)] <= wr_data[(COLS+c)*DW +: DW];
            end
        end
    end
    // word k packs elements 2k (low half) and 2k+1 (high half)
    assign rd_word = {mem[{rd_idx, 1'b1}], mem[{rd_idx, 1'b0}]};
endmodule

// File: rtl/mlp_result_tx.sv
// mlp_result_tx: collects row pairs of the result matrix and streams it as OUT_W-bit words.
// Optional MLP_TX_READY_EN adds result_ready_i backpressure on the output stream.
module mlp_result_tx import mlp_pkg::*; #(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW = DEF_DW,
    parameter int OUT_W = DEF_OUT_W,
    localparam int PW = (ROWS > 2) ? $clog2(ROWS / 2) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pair_valid_i,
    input  logic [PW-1:0]          pair_idx_i,
    input  logic [2*COLS*DW-1:0]   pair_data_i,
`ifdef MLP_TX_READY_EN
    input  logic                   result_ready_i,
`endif
    output logic                   result_valid_o,
    output logic [OUT_W-1:0]       result_payload_o,
    output logic                   done_o,
    output logic                   busy_o,
    output logic                   wr_err_o
);
    localparam int HALF = ROWS / 2;
    localparam int WORDS = ROWS * COLS / 2;
    localparam int CW = $clog2(WORDS);
    tx_state_e state, state_next;
    logic [HALF-1:0] bitmap;
    logic [CW-1:0] cnt, rd_idx;
    logic [OUT_W-1:0] rd_word;
    logic done_q, ready, xfer, last, wr_en, in_range;
`ifdef MLP_TX_READY_EN
    assign ready = result_ready_i;
    assign done_o = done_q & result_ready_i;
`else
    assign ready = 1'b1;
    assign done_o = done_q;
`endif
    assign xfer = result_valid_o & ready;
    assign last = cnt == CW'(WORDS - 1);
    assign in_range = int'(pair_idx_i) < HALF;
    assign wr_en = pair_valid_i & in_range & (state == COLLECT);
    // read one word ahead so the payload register loads the next word on each transfer
    assign rd_idx = (state == SEND) ? cnt + 1'b1 : '0;
    mlp_tx_buffer #(
        .ROWS(ROWS), .COLS(COLS), .DW(DW), .OUT_W(OUT_W), .PW(PW), .CW(CW)
    ) u_buf (
        .clk(clk),
        .wr_en(wr_en),
        .wr_pair(pair_idx_i),
        .wr_data(pair_data_i),
        .rd_idx(rd_idx),
        .rd_word(rd_word)
    );
    always_comb begin
        state_next = state;
        if (state == COLLECT && &bitmap)
            state_next = SEND;
        else if (state == SEND && xfer && last)
            state_next = COLLECT;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap <= '0;
            cnt <= '0;
            result_valid_o <= 1'b0;
            result_payload_o <= '0;
            done_q <= 1'b0;
            busy_o <= 1'b0;
            wr_err_o <= 1'b0;
        end else begin
            busy_o <= state_next == SEND;
            if (pair_valid_i && state == SEND)
                wr_err_o <= 1'b1;
            if (state == COLLECT && state_next == SEND) begin
                cnt <= '0;
                result_valid_o <= 1'b1;
                result_payload_o <= rd_word;
                done_q <= WORDS == 1;
            end else if (state == SEND && xfer) begin
                if (last) begin
                    bitmap <= '0;
                    cnt <= '0;
                    result_valid_o <= 1'b0;
                    result_payload_o <= '0;
                    done_q <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                    result_payload_o <= rd_word;
                    done_q <= cnt + 1'b1 == CW'(WORDS - 1);
                end
            end
            if (wr_en)
                bitmap[pair_idx_i] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mlp_result_tx.sv
// tb_mlp_result_tx: scoreboard bench; expected words are queued from a matrix model when a fill completes.
module tb_mlp_result_tx;
    logic clk = 0;
    logic rst = 1;
    logic pair_valid = 0;
    logic [2:0] pair_idx = 0;
    logic [511:0] pair_data = '0;
    logic ready = 1;
    logic rdy_mode = 0;
    int ph = 0;
    logic result_valid, done, busy, wr_err;
    logic [31:0] payload;
    int total = 0, bad = 0, n_xfer = 0;
    logic [15:0] model [256];
    logic [31:0] q [$];
    logic stalled_prev = 0;
    logic [31:0] prev_p = 0;

    mlp_result_tx dut (
        .clk(clk),
        .rst(rst),
        .pair_valid_i(pair_valid),
        .pair_idx_i(pair_idx),
        .pair_data_i(pair_data),
`ifdef MLP_TX_READY_EN
        .result_ready_i(ready),
`endif
        .result_valid_o(result_valid),
        .result_payload_o(payload),
        .done_o(done),
        .busy_o(busy),
        .wr_err_o(wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] build(input int p, input int off);
        logic [511:0] d;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++)
                d[(r*16+c)*16 +: 16] = 16'((2*p+r)*16 + c + off);
        return d;
    endfunction

    function automatic logic [511:0] fillc(input logic [15:0] v);
        return {32{v}};
    endfunction

    task automatic wr(input int p, input logic [511:0] d, input bit acc);
        pair_valid = 1;
        pair_idx = 3'(p);
        pair_data = d;
        @(posedge clk);
        #1;
        pair_valid = 0;
        if (acc)
            for (int i = 0; i < 32; i++)
                model[2*p*16 + i] = d[i*16 +: 16];
    endtask

    task automatic start_stream();
        check("pre_valid", result_valid, 0);
        for (int k = 0; k < 128; k++)
            q.push_back({model[2*k+1], model[2*k]});
        n_xfer = 0;
        @(posedge clk);
        #1;
        check("start_valid", result_valid, 1);
        check("start_busy", busy, 1);
    endtask

    task automatic fill_all(input int off);
        for (int p = 0; p < 8; p++)
            wr(p, build(p, off), 1);
        start_stream();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stream_end_timeout", 32'(n < 2000), 1);
        check("nwords", n_xfer, 128);
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            ready = (ph == 0 || ph == 3);
            ph = (ph + 1) % 4;
        end else
            ready = 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stalled_prev) begin
                check("hold_valid", result_valid, 1);
                check("hold_payload", payload, prev_p);
            end
            if (result_valid && ready) begin
                if (q.size() == 0)
                    check("extra_word", 0, 1);
                else begin
                    check("word", payload, q.pop_front());
                    check("done_last", done, 32'(q.size() == 0));
                    n_xfer++;
                end
            end else if (done)
                check("done_stray", done, 0);
            stalled_prev = result_valid && !ready;
            prev_p = payload;
        end else
            stalled_prev = 0;
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", result_valid, 0);
        check("rst_payload", payload, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_err", wr_err, 0);
        rst = 0;
        // in-order fill, values row*16+col
        fill_all(0);
        check("word0_model", q[0], 32'h0001_0000);
        wait_idle();
        // scrambled order with pair 3 overwritten
        wr(7, build(7, 'h40), 1);
        wr(3, fillc(16'hAAAA), 1);
        wr(0, build(0, 'h40), 1);
        wr(5, build(5, 'h40), 1);
        wr(3, fillc(16'h1234), 1);
        wr(1, build(1, 'h40), 1);
        wr(6, build(6, 'h40), 1);
        wr(2, build(2, 'h40), 1);
        repeat (2) @(posedge clk);
        #1;
        check("no_send_before_last", busy, 0);
        wr(4, build(4, 'h40), 1);
        start_stream();
        wait_idle();
        // dropped writes during SEND
        fill_all(0);
        repeat (40) begin @(posedge clk); #1; end
        wr(2, fillc(16'hDEAD), 0);
        check("wr_err_set", wr_err, 1);
        repeat (86) begin @(posedge clk); #1; end
        check("at_last_word", done, 1);
        wr(2, fillc(16'hBEEF), 0);
        wait_idle();
        check("wr_err_sticky", wr_err, 1);
        // reset mid-stream
        fill_all(0);
        repeat (60) begin @(posedge clk); #1; end
        rst = 1;
        #1;
        check("rst_mid_valid", result_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_wr_err", wr_err, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 0;
        fill_all('h20);
        wait_idle();
        // back-to-back matrices, B = A + 0x100
        fill_all(0);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", done, 1);
        @(posedge clk);
        #1;
        check("nwords_a", n_xfer, 128);
        check("idle_after_done", busy, 0);
        fill_all('h100);
        check("b_word0", q[0], 32'h0101_0100);
        wait_idle();
        check("wr_err_clear", wr_err, 0);
`ifdef MLP_TX_READY_EN
        rdy_mode = 1;
        fill_all(7);
        wait_idle();
        rdy_mode = 0;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
